ram_device: RTL and testbench

- Device-side responder for the mobo peripheral bus: the RAM that sits on the far end of ram_ctrl/ram_stat, addr, data_out and data_in.
- Accepts one read or write per four-phase handshake and emulates a configurable access latency.
- Drives a word-addressed internal memory.
- Answers with a done or error status, then waits for the controller to drop ctrl before it returns to idle.

---
 rtl/ram_device_pkg.sv | 31 +++
 rtl/ram_device_array.sv | 49 ++++
 rtl/ram_device.sv | 132 +++++++++++++
 tb/tb_ram_device.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ram_device_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_device_pkg
// Description : Shared handshake pin codes and device-side state encodings
//               for the mobo peripheral-bus RAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_device_pkg;

    // Control pins (bit masks on ctrl[1:0])
    localparam logic [1:0] C_CTRL_READ  = 2'b01;
    localparam logic [1:0] C_CTRL_WRITE = 2'b10;

    // Status codes driven on stat
    localparam logic [1:0] C_STAT_IDLE  = 2'd0;
    localparam logic [1:0] C_STAT_DONE  = 2'd1;
    localparam logic [1:0] C_STAT_ERR   = 2'd2;

    // Latency counter width
    localparam int C_CNT_WIDTH = 8;

    // Device state space, kept apart from the controller's own states
    typedef enum logic [1:0] {
        RDEV_IDLE = 2'd0,
        RDEV_WAIT = 2'd1,
        RDEV_DONE = 2'd2,
        RDEV_ERR  = 2'd3
    } rdev_state_t;

endpackage : ram_device_pkg
`default_nettype wire

// File: rtl/ram_device_array.sv
`default_nettype none
// ============================================================================
// Module      : ram_array
// Description : Single-port synchronous word memory with write enable and a
//               registered, enable-gated read port. The read register holds
//               its value between reads and clears on reset; the storage
//               itself is never cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_array
    import ram_device_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [WORD_WIDTH-1:0] i_wdata,
    output logic [WORD_WIDTH-1:0] o_rdata
);

    localparam int C_DEPTH = 1 << ADDR_WIDTH;

    logic [WORD_WIDTH-1:0] r_mem [C_DEPTH];
    logic [WORD_WIDTH-1:0] r_rdata;

    // Storage write; no reset so contents survive a device reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Registered read; holds the last read word until the next read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : ram_array
`default_nettype wire

// File: rtl/ram_device.sv
`default_nettype none
// ============================================================================
// Module      : ram_device
// Description : Device-side responder for the mobo peripheral bus. Accepts one
//               read or write per four-phase handshake, waits LATENCY cycles,
//               performs the access and reports done/error until the
//               controller drops ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_device
    import ram_device_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] ctrl,
    output logic [WORD_WIDTH-1:0] stat,
    input  logic [WORD_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] data_out
);

    rdev_state_t            r_state;
    rdev_state_t            w_state_nxt;
    logic [C_CNT_WIDTH-1:0] r_cnt;
    logic [C_CNT_WIDTH-1:0] w_cnt_nxt;
    logic [1:0]             r_stat;
    logic [1:0]             w_stat_nxt;
    logic                   r_is_write;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [WORD_WIDTH-1:0]  r_wdata;
    logic                   w_req;
    logic                   w_bad;
    logic                   w_capture;
    logic                   w_mem_we;
    logic                   w_mem_re;

    // A request is any of the two op bits; both set or an address beyond the
    // array (compared over the full bus width) is rejected.
    assign w_req = (ctrl[1:0] & (C_CTRL_READ | C_CTRL_WRITE)) != 2'b00;
    assign w_bad = (ctrl[1:0] == (C_CTRL_READ | C_CTRL_WRITE))
                || ((addr >> ADDR_WIDTH) != '0);

    // State, latency counter and status register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RDEV_IDLE;
            r_cnt   <= '0;
            r_stat  <= C_STAT_IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stat  <= w_stat_nxt;
        end
    end

    // Request capture; later bus changes are ignored until the next accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (w_capture) begin
            r_is_write <= (ctrl[1:0] & C_CTRL_WRITE) != 2'b00;
            r_addr     <= addr[ADDR_WIDTH-1:0];
            r_wdata    <= data_in;
        end
    end

    // Next-state, status and memory strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stat_nxt  = r_stat;
        w_capture   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        case (r_state)
            RDEV_IDLE: begin
                if (w_req) begin
                    w_capture = 1'b1;
                    if (w_bad) begin
                        w_state_nxt = RDEV_ERR;
                        w_stat_nxt  = C_STAT_ERR;
                    end else begin
                        w_state_nxt = RDEV_WAIT;
                        w_cnt_nxt   = C_CNT_WIDTH'(LATENCY);
                    end
                end
            end
            RDEV_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - C_CNT_WIDTH'(1);
                end else begin
                    w_mem_we    = r_is_write;
                    w_mem_re    = !r_is_write;
                    w_stat_nxt  = C_STAT_DONE;
                    w_state_nxt = RDEV_DONE;
                end
            end
            RDEV_DONE, RDEV_ERR: begin
                if (ctrl == '0) begin
                    w_stat_nxt  = C_STAT_IDLE;
                    w_state_nxt = RDEV_IDLE;
                end
            end
            default: begin
                w_state_nxt = RDEV_IDLE;
            end
        endcase
    end

    ram_array #(
        .WORD_WIDTH (WORD_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (data_out)
    );

    assign stat = WORD_WIDTH'(r_stat);

endmodule : ram_device
`default_nettype wire

// File: tb/tb_ram_device.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_device
// Description : Directed self-checking bench for ram_device, with one
//               LATENCY=2 instance and one LATENCY=0 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_device;

    localparam int C_W = 32;

    logic           clk;
    logic           rst;
    logic [C_W-1:0] ctrl, addr, data_in;
    logic [C_W-1:0] stat, data_out;
    logic [C_W-1:0] ctrl0, addr0, data_in0;
    logic [C_W-1:0] stat0, data_out0;

    int n_checks;
    int n_errors;

    ram_device #(.WORD_WIDTH(C_W), .ADDR_WIDTH(10), .LATENCY(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .ctrl     (ctrl),
        .stat     (stat),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    ram_device #(.WORD_WIDTH(C_W), .ADDR_WIDTH(10), .LATENCY(0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .ctrl     (ctrl0),
        .stat     (stat0),
        .addr     (addr0),
        .data_in  (data_in0),
        .data_out (data_out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [C_W-1:0] got,
                         input logic [C_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full LATENCY=2 access: request held through E0..E3, then released
    task automatic access(input logic [1:0] op, input logic [C_W-1:0] a,
                          input logic [C_W-1:0] d);
        ctrl    = C_W'(op);
        addr    = a;
        data_in = d;
        repeat (4) tick();
        ctrl = '0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        ctrl     = '0; addr  = '0; data_in  = '0;
        ctrl0    = '0; addr0 = '0; data_in0 = '0;
        repeat (2) tick();
        check("reset_stat", stat, 32'd0);
        check("reset_dout", data_out, 32'd0);
        check("reset_stat_l0", stat0, 32'd0);
        rst = 1'b0;
        tick();

        // Write 0xDEADBEEF to 5 and observe the latency
        ctrl = 32'd2; addr = 32'd5; data_in = 32'hDEADBEEF;
        repeat (3) tick();
        check("wr_wait_e2", stat, 32'd0);
        tick();
        check("wr_done_e3", stat, 32'd1);
        ctrl = '0;
        tick();
        check("wr_release", stat, 32'd0);

        // Read back
        ctrl = 32'd1; addr = 32'd5;
        repeat (4) tick();
        check("rd_done_e3", stat, 32'd1);
        check("rd_data", data_out, 32'hDEADBEEF);
        ctrl = '0;
        tick();
        check("rd_release", stat, 32'd0);

        // Out-of-range address
        ctrl = 32'd1; addr = 32'd1024;
        tick();
        check("oor_err", stat, 32'd2);
        check("oor_dout_kept", data_out, 32'hDEADBEEF);
        repeat (2) tick();
        check("oor_err_held", stat, 32'd2);
        ctrl = '0;
        tick();
        check("oor_release", stat, 32'd0);

        // Both op bits set: no effect on mem[7]
        access(2'd2, 32'd7, 32'h0000_0077);
        ctrl = 32'd3; addr = 32'd7; data_in = 32'h0000_0099;
        tick();
        check("both_err", stat, 32'd2);
        ctrl = '0;
        tick();
        check("both_release", stat, 32'd0);
        access(2'd1, 32'd7, 32'd0);
        check("both_mem7", data_out, 32'h0000_0077);

        // Bus changes during WAIT are ignored; ctrl dropped mid-WAIT
        ctrl = 32'd2; addr = 32'd9; data_in = 32'h11;
        tick();
        ctrl = '0; addr = 32'd3; data_in = 32'h22;
        repeat (2) tick();
        check("glitch_wait", stat, 32'd0);
        tick();
        check("glitch_done", stat, 32'd1);
        tick();
        check("glitch_idle", stat, 32'd0);
        tick();
        check("glitch_idle2", stat, 32'd0);
        access(2'd1, 32'd9, 32'd0);
        check("glitch_mem9", data_out, 32'h11);

        // Zero-latency instance
        ctrl0 = 32'd2; addr0 = 32'd3; data_in0 = 32'hA5;
        tick();
        tick();
        check("l0_wr_done", stat0, 32'd1);
        ctrl0 = '0;
        tick();
        ctrl0 = 32'd1;
        tick();
        check("l0_rd_e0", stat0, 32'd0);
        tick();
        check("l0_rd_done", stat0, 32'd1);
        check("l0_rd_data", data_out0, 32'hA5);
        ctrl0 = '0;
        tick();
        check("l0_release", stat0, 32'd0);

        // Asynchronous reset during a write's WAIT
        access(2'd2, 32'd4, 32'h44);
        ctrl = 32'd2; addr = 32'd4; data_in = 32'h55;
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_stat", stat, 32'd0);
        check("arst_dout", data_out, 32'd0);
        ctrl = '0;
        #1 rst = 1'b0;
        tick();
        access(2'd1, 32'd4, 32'd0);
        check("arst_mem4", data_out, 32'h44);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Safety net against a hung simulation
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_ram_device
`default_nettype wire
